dekatron_counter: RTL and testbench

Synchronous model of one decade-counter stage built on a dekatron glow-transfer tube. It contains three parts. A guide-pulse sequencer (DekatronPulseSender function) drives two active-low guide lines. A tube model (DekatronBulb function) moves a one-hot glow position one cathode per pulse pair. A one-hot-to-BCD decoder (BinToDbc function) produces an 8-4-2-1 digit for the display. The stage is the counting/display element used by the dekatron-based datapath.

---
 rtl/dekatron_counter.sv | 145 ++++++++++++++
 tb/tb_dekatron_counter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dekatron_counter.sv
// Decade stage of a dekatron counter: guide-pulse sequencer, glow tube model
// and one-hot to BCD decoder.
//
// Ports:
//   Clk, Rst_n        clock, async active-low reset
//   En, Reverse       start a step when idle / step direction (latched at start)
//   Set, In[9:0]      synchronous one-hot load of the glow position
//   PulseRight_n      registered guide line, active-low
//   PulseLeft_n       registered guide line, active-low
//   Out[9:0]          one-hot glow position
//   DecOut[3:0]       BCD digit of Out
//   Ready             glow rests on a main cathode
module dekatron_counter (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       En,
  input  logic       Reverse,
  input  logic       Set,
  input  logic [9:0] In,
  output logic       PulseRight_n,
  output logic       PulseLeft_n,
  output logic [9:0] Out,
  output logic [3:0] DecOut,
  output logic       Ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_G1,
    S_G2
  } seq_e;

  typedef enum logic [2:0] {
    T_CATH,
    T_FG1,
    T_FG2,
    T_RG1,
    T_RG2
  } tube_e;

  function automatic logic [3:0] lsb_idx(
    input logic [9:0] v
  );
    logic [3:0] idx;
    idx = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (v[k]) idx = 4'(k);
    end
    return idx;
  endfunction

  seq_e       seq_q, seq_d;
  logic       dir_q, dir_d;
  logic       pr_q, pr_d;
  logic       pl_q, pl_d;
  tube_e      tube_q, tube_d;
  logic [3:0] pos_q, pos_d;

  // Sequencer: a started step always runs G1, G2 to completion.
  always_comb begin
    seq_d = seq_q;
    dir_d = dir_q;
    unique case (seq_q)
      S_IDLE: begin
        if (En) begin
          seq_d = S_G1;
          dir_d = Reverse;
        end
      end
      S_G1:    seq_d = S_G2;
      S_G2:    seq_d = S_IDLE;
      default: seq_d = S_IDLE;
    endcase
  end

  // Lines follow the next state so they change on the same edge.
  always_comb begin
    pr_d = !((seq_d == S_G1 && !dir_d) ||
             (seq_d == S_G2 && dir_d));
    pl_d = !((seq_d == S_G1 && dir_d) ||
             (seq_d == S_G2 && !dir_d));
  end

  // Tube: reacts to the registered guide lines.
  always_comb begin
    tube_d = tube_q;
    pos_d  = pos_q;
    unique case (tube_q)
      T_CATH: begin
        if (!pr_q && pl_q)      tube_d = T_FG1;
        else if (pr_q && !pl_q) tube_d = T_RG1;
      end
      T_FG1: begin
        if (!pl_q)             tube_d = T_FG2;
        else if (pr_q && pl_q) tube_d = T_CATH;
      end
      T_FG2: begin
        if (pr_q && pl_q) begin
          tube_d = T_CATH;
          pos_d  = (pos_q == 4'd9) ? 4'd0 : pos_q + 4'd1;
        end
      end
      T_RG1: begin
        if (!pr_q)             tube_d = T_RG2;
        else if (pr_q && pl_q) tube_d = T_CATH;
      end
      T_RG2: begin
        if (pr_q && pl_q) begin
          tube_d = T_CATH;
          pos_d  = (pos_q == 4'd0) ? 4'd9 : pos_q - 4'd1;
        end
      end
      default: tube_d = T_CATH;
    endcase
    if (Set && (In != 10'd0)) begin
      tube_d = T_CATH;
      pos_d  = lsb_idx(In);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      seq_q  <= S_IDLE;
      dir_q  <= 1'b0;
      pr_q   <= 1'b1;
      pl_q   <= 1'b1;
      tube_q <= T_CATH;
      pos_q  <= 4'd0;
    end else begin
      seq_q  <= seq_d;
      dir_q  <= dir_d;
      pr_q   <= pr_d;
      pl_q   <= pl_d;
      tube_q <= tube_d;
      pos_q  <= pos_d;
    end
  end

  assign PulseRight_n = pr_q;
  assign PulseLeft_n  = pl_q;
  assign Out          = 10'd1 << pos_q;
  assign DecOut       = lsb_idx(Out);
  assign Ready        = (tube_q == T_CATH);

endmodule

// File: tb/tb_dekatron_counter.sv
// Bench for dekatron_counter: directed steps plus random
// stimulus against a cycle model of the stage.
module tb_dekatron_counter;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b1;
  logic       En = 1'b0;
  logic       Reverse = 1'b0;
  logic       Set = 1'b0;
  logic [9:0] In = 10'd0;
  logic       PulseRight_n;
  logic       PulseLeft_n;
  logic [9:0] Out;
  logic [3:0] DecOut;
  logic       Ready;

  int total = 0;
  int bad = 0;

  // model: phase 0 idle, 1 first guide, 2 second guide
  int m_ph, m_pos, m_ts;
  bit m_dir, m_rn, m_ln;

  dekatron_counter dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .En           (En),
    .Reverse      (Reverse),
    .Set          (Set),
    .In           (In),
    .PulseRight_n (PulseRight_n),
    .PulseLeft_n  (PulseLeft_n),
    .Out          (Out),
    .DecOut       (DecOut),
    .Ready        (Ready)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_dir = 0; m_rn = 1; m_ln = 1;
    m_ts = 0; m_pos = 0;
  endtask

  task automatic model_step();
    bit rn, ln;
    rn = m_rn;
    ln = m_ln;
    // tube, +1/+2 forward halves, -1/-2 reverse halves
    case (m_ts)
      0: if (!rn && ln) m_ts = 1;
         else if (rn && !ln) m_ts = -1;
      1: if (!ln) m_ts = 2;
         else if (rn && ln) m_ts = 0;
      2: if (rn && ln) begin
           m_ts = 0; m_pos = (m_pos + 1) % 10;
         end
      -1: if (!rn) m_ts = -2;
          else if (rn && ln) m_ts = 0;
      -2: if (rn && ln) begin
            m_ts = 0; m_pos = (m_pos + 9) % 10;
          end
      default: m_ts = 0;
    endcase
    if (Set && In != 0) begin
      m_ts = 0;
      for (int k = 9; k >= 0; k--)
        if (In[k]) m_pos = k;
    end
    if (m_ph == 0) begin
      if (En) begin m_ph = 1; m_dir = Reverse; end
    end else if (m_ph == 1) m_ph = 2;
    else m_ph = 0;
    m_rn = !((m_ph == 1 && !m_dir) || (m_ph == 2 && m_dir));
    m_ln = !((m_ph == 1 && m_dir) || (m_ph == 2 && !m_dir));
  endtask

  task automatic chk_model();
    logic [9:0] oh;
    oh = 10'd1 << m_pos;
    chk("out", 32'(Out), 32'(oh));
    chk("dec", 32'(DecOut), 32'(m_pos));
    chk("ready", 32'(Ready), 32'(m_ts == 0));
    chk("right_n", 32'(PulseRight_n), 32'(m_rn));
    chk("left_n", 32'(PulseLeft_n), 32'(m_ln));
  endtask

  task automatic tick();
    @(posedge Clk);
    if (!Rst_n) model_reset();
    else model_step();
    #1;
    chk_model();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out"}, 32'(Out), 32'h001);
    chk({tag, "_dec"}, 32'(DecOut), 32'd0);
    chk({tag, "_rdy"}, 32'(Ready), 32'd1);
    chk({tag, "_rn"}, 32'(PulseRight_n), 32'd1);
    chk({tag, "_ln"}, 32'(PulseLeft_n), 32'd1);
  endtask

  initial begin
    bit pr, pl;
    int changes, first_chg;
    logic [3:0] pd;
    model_reset();
    #1 Rst_n = 1'b0;
    #1 chk_reset_vals("rst");
    tick();
    tick();
    Rst_n = 1'b1;

    // idle with En low
    for (int i = 0; i < 5; i++) tick();
    chk_reset_vals("idle");

    // forward count with wrap
    En = 1'b1;
    Reverse = 1'b0;
    changes = 0;
    first_chg = 0;
    pd = DecOut;
    pr = PulseRight_n;
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (!PulseLeft_n) chk("fwd_order", 32'(pr), 32'd0);
      if (DecOut != pd) begin
        changes++;
        if (first_chg == 0) first_chg = i;
      end
      pd = DecOut;
      pr = PulseRight_n;
    end
    chk("fwd_changes", 32'(changes), 32'd10);
    chk("fwd_latency", 32'(first_chg), 32'd4);
    chk("fwd_wrap", 32'(DecOut), 32'd0);
    chk("fwd_in_g1", 32'(PulseRight_n), 32'd0);

    // drop En during G1: step completes
    En = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("drop_dec", 32'(DecOut), 32'd1);
    chk("drop_rdy", 32'(Ready), 32'd1);
    chk("drop_rn", 32'(PulseRight_n), 32'd1);
    chk("drop_ln", 32'(PulseLeft_n), 32'd1);

    // load 2, then Set with zero In is ignored
    Set = 1'b1;
    In = 10'b0000000100;
    tick();
    chk("set2_dec", 32'(DecOut), 32'd2);
    In = 10'd0;
    tick();
    chk("set0_dec", 32'(DecOut), 32'd2);
    Set = 1'b0;

    // reverse count 2 -> 1, 0, 9
    En = 1'b1;
    Reverse = 1'b1;
    pl = PulseLeft_n;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!PulseRight_n) chk("rev_order", 32'(pl), 32'd0);
      pl = PulseLeft_n;
    end
    chk("rev_wrap", 32'(DecOut), 32'd9);
    chk("rev_in_g1", 32'(PulseLeft_n), 32'd0);

    // flip direction mid-step
    Reverse = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("flip_old", 32'(DecOut), 32'd8);
    for (int i = 0; i < 3; i++) tick();
    chk("flip_new", 32'(DecOut), 32'd9);

    // Set while counting
    tick();
    Set = 1'b1;
    In = 10'b0001000000;
    tick();
    Set = 1'b0;
    In = 10'd0;
    chk("set6_out", 32'(Out), 32'h040);
    chk("set6_dec", 32'(DecOut), 32'd6);
    chk("set6_rdy", 32'(Ready), 32'd1);
    for (int i = 0; i < 6; i++) tick();

    // random stimulus
    for (int i = 0; i < 400; i++) begin
      En = ($urandom_range(0, 3) != 0);
      Reverse = ($urandom_range(0, 5) == 0) ? ~Reverse : Reverse;
      Set = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 2))
        0: In = 10'd0;
        1: In = 10'd1 << $urandom_range(0, 9);
        default: In = 10'($urandom);
      endcase
      tick();
    end
    Set = 1'b0;
    In = 10'd0;

    // async reset mid-transfer
    En = 1'b1;
    Reverse = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 Rst_n = 1'b0;
    #1 chk_reset_vals("arst");
    model_reset();
    tick();
    Rst_n = 1'b1;
    En = 1'b0;
    tick();
    chk_reset_vals("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
